// File: rtl/tl_simple_manager.sv
// Single-client TileLink-C manager backing a small on-chip data array.
// Serves Get/Acquire on A and Release on C, one transaction at a time; no B channel.

package BundleST;
  localparam int AddrW   = 32;
  localparam int DataW   = 128;
  localparam int SourceW = 4;
  localparam int SinkW   = 4;
  localparam int SizeW   = 4;

  typedef struct packed {
    logic [2:0]         opcode;
    logic [2:0]         param;
    logic [SizeW-1:0]   size;
    logic [SourceW-1:0] source;
    logic [AddrW-1:0]   address;
    logic [DataW/8-1:0] mask;
    logic               corrupt;
    logic [DataW-1:0]   data;
  } TLBundleAST;

  typedef struct packed {
    logic [2:0]         opcode;
    logic [2:0]         param;
    logic [SizeW-1:0]   size;
    logic [SourceW-1:0] source;
    logic [AddrW-1:0]   address;
    logic               corrupt;
    logic [DataW-1:0]   data;
  } TLBundleCST;

  typedef struct packed {
    logic [2:0]         opcode;
    logic [1:0]         param;
    logic [SizeW-1:0]   size;
    logic [SourceW-1:0] source;
    logic [SinkW-1:0]   sink;
    logic               denied;
    logic               corrupt;
    logic [DataW-1:0]   data;
  } TLBundleDST;

  typedef struct packed {
    logic [SinkW-1:0] sink;
  } TLBundleEST;
endpackage

module tl_simple_manager #(
  parameter int MEM_BEATS = 64,
  parameter int SINK_ID   = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  BundleST::TLBundleAST a_bits,
  input  logic                 c_valid,
  output logic                 c_ready,
  input  BundleST::TLBundleCST c_bits,
  output logic                 d_valid,
  input  logic                 d_ready,
  output BundleST::TLBundleDST d_bits,
  input  logic                 e_valid,
  output logic                 e_ready,
  input  BundleST::TLBundleEST e_bits,
  output logic                 err
);
  localparam int IdxW = $clog2(MEM_BEATS);

  localparam logic [2:0] OpGet           = 3'd4;
  localparam logic [2:0] OpAcqBlock      = 3'd6;
  localparam logic [2:0] OpAcqPerm       = 3'd7;
  localparam logic [2:0] OpRelease       = 3'd6;
  localparam logic [2:0] OpReleaseData   = 3'd7;
  localparam logic [2:0] OpAccessAckData = 3'd1;
  localparam logic [2:0] OpGrant         = 3'd4;
  localparam logic [2:0] OpGrantData     = 3'd5;
  localparam logic [2:0] OpReleaseAck    = 3'd6;

  typedef enum logic [2:0] {IDLE, A_RESP, WAIT_E, C_DATA, C_ACK} stateT;

  stateT                            state, stateNext;
  logic [2:0]                       opcodeQ;
  logic [BundleST::SourceW-1:0]     sourceQ;
  logic [BundleST::SizeW-1:0]       sizeQ;
  logic [IdxW-1:0]                  baseQ;
  logic [1:0]                       beatQ, lastQ;
  logic [BundleST::DataW-1:0]       mem [MEM_BEATS];

  logic [1:0]                 aLast, cLast;
  logic [IdxW-1:0]            aBase, cBase, memIdx, memWIdx;
  logic                       aFire, cFire, dFire, eFire;
  logic                       latchA, latchC, beatInc, memWe, setErr;
  logic [BundleST::DataW-1:0] rdData;
  logic [BundleST::SinkW-1:0] sinkId;
  logic                       unusedBits;

  // Last beat index (beats-1); oversized requests are clamped to four beats.
  function automatic logic [1:0] lastBeatOf(input logic [BundleST::SizeW-1:0] size);
    if (size <= 4'd4) return 2'd0;
    else if (size == 4'd5) return 2'd1;
    else return 2'd3;
  endfunction

  assign sinkId  = BundleST::SinkW'(SINK_ID);
  assign aLast   = (a_bits.opcode == OpAcqPerm) ? 2'd0 : lastBeatOf(a_bits.size);
  assign cLast   = lastBeatOf(c_bits.size);
  assign aBase   = a_bits.address[4 +: IdxW] & ~IdxW'(aLast);
  assign cBase   = c_bits.address[4 +: IdxW] & ~IdxW'(cLast);
  assign memIdx  = baseQ + IdxW'(beatQ);
  assign rdData  = mem[memIdx];
  assign aFire   = a_valid && a_ready;
  assign cFire   = c_valid && c_ready;
  assign dFire   = d_valid && d_ready;
  assign eFire   = e_valid && e_ready;
  assign e_ready = !reset;
  assign unusedBits = ^{a_bits.param, a_bits.mask, a_bits.corrupt, a_bits.address,
                        c_bits.param, c_bits.corrupt, c_bits.address};

  always_comb begin
    stateNext = state;
    a_ready   = 1'b0;
    c_ready   = 1'b0;
    d_valid   = 1'b0;
    d_bits    = '0;
    latchA    = 1'b0;
    latchC    = 1'b0;
    beatInc   = 1'b0;
    memWe     = 1'b0;
    memWIdx   = memIdx;
    setErr    = eFire && (state != WAIT_E);
    case (state)
      IDLE: begin
        c_ready = !reset;
        a_ready = !reset && !c_valid;
        if (cFire) begin
          if (c_bits.opcode == OpRelease) begin
            latchC    = 1'b1;
            setErr    = setErr || (c_bits.size > 4'd6);
            stateNext = C_ACK;
          end else if (c_bits.opcode == OpReleaseData) begin
            latchC    = 1'b1;
            memWe     = 1'b1;
            memWIdx   = cBase;
            setErr    = setErr || (c_bits.size > 4'd6);
            stateNext = (cLast != 2'd0) ? C_DATA : C_ACK;
          end else begin
            setErr = 1'b1;
          end
        end else if (aFire) begin
          if (a_bits.opcode == OpGet || a_bits.opcode == OpAcqBlock || a_bits.opcode == OpAcqPerm) begin
            latchA    = 1'b1;
            setErr    = setErr || (a_bits.size > 4'd6);
            stateNext = A_RESP;
          end else begin
            setErr = 1'b1;
          end
        end
      end
      A_RESP: begin
        d_valid       = 1'b1;
        d_bits.opcode = (opcodeQ == OpGet) ? OpAccessAckData :
                        (opcodeQ == OpAcqBlock) ? OpGrantData : OpGrant;
        d_bits.size   = sizeQ;
        d_bits.source = sourceQ;
        d_bits.sink   = sinkId;
        d_bits.data   = (opcodeQ == OpAcqPerm) ? '0 : rdData;
        if (dFire) begin
          beatInc = 1'b1;
          if (beatQ == lastQ) stateNext = (opcodeQ == OpGet) ? IDLE : WAIT_E;
        end
      end
      WAIT_E: begin
        if (eFire) begin
          setErr    = (e_bits.sink != sinkId);
          stateNext = IDLE;
        end
      end
      C_DATA: begin
        c_ready = 1'b1;
        if (cFire) begin
          memWe   = 1'b1;
          beatInc = 1'b1;
          setErr  = setErr || (c_bits.opcode != OpReleaseData);
          if (beatQ == lastQ) stateNext = C_ACK;
        end
      end
      C_ACK: begin
        d_valid       = 1'b1;
        d_bits.opcode = OpReleaseAck;
        d_bits.size   = sizeQ;
        d_bits.source = sourceQ;
        d_bits.sink   = sinkId;
        if (dFire) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Beat 0 of a ReleaseData is written on acceptance, so the counter resumes at 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      opcodeQ <= '0;
      sourceQ <= '0;
      sizeQ   <= '0;
      baseQ   <= '0;
      beatQ   <= '0;
      lastQ   <= '0;
      err     <= 1'b0;
    end else begin
      if (latchA) begin
        opcodeQ <= a_bits.opcode;
        sourceQ <= a_bits.source;
        sizeQ   <= a_bits.size;
        baseQ   <= aBase;
        lastQ   <= aLast;
        beatQ   <= 2'd0;
      end else if (latchC) begin
        opcodeQ <= c_bits.opcode;
        sourceQ <= c_bits.source;
        sizeQ   <= c_bits.size;
        baseQ   <= cBase;
        lastQ   <= cLast;
        beatQ   <= 2'd1;
      end else if (beatInc) begin
        beatQ <= beatQ + 2'd1;
      end
      if (setErr) err <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (memWe) mem[memWIdx] <= c_bits.data;
  end
endmodule

// File: tb/tb_tl_simple_manager.sv
// Bench for tl_simple_manager: directed scenarios plus randomized transactions,
// checked against an array-based model of the backing store.

module tb_tl_simple_manager;
  import BundleST::*;

  localparam int MEM     = 64;
  localparam int SINK_ID = 5;

  logic       clock = 1'b0;
  logic       reset;
  logic       a_valid, a_ready, c_valid, c_ready, d_valid, d_ready, e_valid, e_ready, err;
  TLBundleAST aBits;
  TLBundleCST cBits;
  TLBundleDST dBits;
  TLBundleEST eBits;

  int           compared   = 0;
  int           mismatched = 0;
  logic [127:0] refMem [MEM];
  bit           errExp     = 1'b0;

  tl_simple_manager #(.MEM_BEATS(MEM), .SINK_ID(SINK_ID)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_bits(aBits),
    .c_valid(c_valid), .c_ready(c_ready), .c_bits(cBits),
    .d_valid(d_valid), .d_ready(d_ready), .d_bits(dBits),
    .e_valid(e_valid), .e_ready(e_ready), .e_bits(eBits),
    .err(err)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int beatsOf(input int size);
    if (size <= 4) return 1;
    if (size == 5) return 2;
    return 4;
  endfunction

  function automatic int baseOf(input int unsigned addr, input int beats);
    int idx;
    idx = int'((addr / 16) % MEM);
    return idx - (idx % beats);
  endfunction

  function automatic TLBundleDST expD(input int op, input int size, input int src, input logic [127:0] data);
    TLBundleDST d;
    d        = '0;
    d.opcode = 3'(op);
    d.size   = 4'(size);
    d.source = 4'(src);
    d.sink   = 4'(SINK_ID);
    d.data   = data;
    return d;
  endfunction

  task automatic aSend(input int op, input int param, input int src, input int size, input int unsigned addr);
    int n = 0;
    @(negedge clock);
    aBits         = '0;
    aBits.opcode  = 3'(op);
    aBits.param   = 3'(param);
    aBits.size    = 4'(size);
    aBits.source  = 4'(src);
    aBits.address = addr;
    aBits.mask    = '1;
    a_valid       = 1'b1;
    #1;
    while (!a_ready && n < 20) begin
      @(negedge clock); #1; n++;
    end
    checkOutput("aAccept", 256'(n < 20), 256'(1));
    @(posedge clock); #1;
    a_valid = 1'b0;
  endtask

  task automatic cSend(input int op, input int src, input int size, input int unsigned addr, input logic [127:0] data);
    int n = 0;
    @(negedge clock);
    cBits         = '0;
    cBits.opcode  = 3'(op);
    cBits.size    = 4'(size);
    cBits.source  = 4'(src);
    cBits.address = addr;
    cBits.data    = data;
    c_valid       = 1'b1;
    #1;
    while (!c_ready && n < 20) begin
      @(negedge clock); #1; n++;
    end
    checkOutput("cAccept", 256'(n < 20), 256'(1));
    @(posedge clock); #1;
    c_valid = 1'b0;
  endtask

  // Collects nBeats D beats; a stalled beat must still equal the expected beat.
  task automatic dExpect(input string tag, input int nBeats, input int op, input int size, input int src,
                         input int base, input bit fromMem, input bit toggle);
    int k = 0;
    int cyc = 0;
    logic [127:0] data;
    while (k < nBeats && cyc < 40) begin
      @(negedge clock);
      d_ready = toggle ? (cyc % 3 == 0) : 1'b1;
      #1;
      if (cyc == 0) checkOutput({tag, ":latency"}, 256'(d_valid), 256'(1));
      if (d_valid) begin
        data = fromMem ? refMem[(base + k) % MEM] : '0;
        checkOutput({tag, ":beat"}, 256'(dBits), 256'(expD(op, size, src, data)));
        if (d_ready) k++;
      end
      @(posedge clock);
      cyc++;
    end
    checkOutput({tag, ":count"}, 256'(k), 256'(nBeats));
    #1 d_ready = 1'b0;
    @(negedge clock); #1;
    checkOutput({tag, ":done"}, 256'(d_valid), 256'(0));
  endtask

  task automatic eSend(input int sink);
    @(negedge clock); #1;
    checkOutput("aReadyWaitE", 256'(a_ready), 256'(0));
    eBits.sink = 4'(sink);
    e_valid    = 1'b1;
    #1;
    checkOutput("eReady", 256'(e_ready), 256'(1));
    @(posedge clock); #1;
    e_valid = 1'b0;
    @(negedge clock); #1;
    checkOutput("aReadyAfterE", 256'(a_ready), 256'(1));
  endtask

  task automatic releaseBurst(input int src, input int size, input int unsigned addr,
                              input bit useFixed, input logic [127:0] fixedBase, input bit toggle);
    int beats = beatsOf(size);
    int base  = baseOf(addr, beats);
    logic [127:0] d;
    for (int k = 0; k < beats; k++) begin
      d = useFixed ? fixedBase + 128'(k) : {$urandom, $urandom, $urandom, $urandom};
      refMem[(base + k) % MEM] = d;
      cSend(7, src, size, addr, d);
    end
    dExpect("releaseAck", 1, 6, size, src, 0, 1'b0, toggle);
  endtask

  // One randomized transaction of a randomly chosen kind.
  task automatic applyStimulus();
    int kind   = $urandom_range(0, 4);
    int src    = $urandom_range(0, 15);
    int unsigned addr = $urandom;
    bit toggle = 1'($urandom_range(0, 1));
    int size;
    case (kind)
      0: begin
        size = $urandom_range(0, 6);
        aSend(4, 0, src, size, addr);
        dExpect("rndGet", beatsOf(size), 1, size, src, baseOf(addr, beatsOf(size)), 1'b1, toggle);
      end
      1: begin
        size = $urandom_range(4, 6);
        aSend(6, 1, src, size, addr);
        dExpect("rndAcqBlock", beatsOf(size), 5, size, src, baseOf(addr, beatsOf(size)), 1'b1, toggle);
        eSend(SINK_ID);
      end
      2: begin
        size = $urandom_range(0, 6);
        aSend(7, 1, src, size, addr);
        dExpect("rndAcqPerm", 1, 4, size, src, 0, 1'b0, toggle);
        eSend(SINK_ID);
      end
      3: releaseBurst(src, $urandom_range(0, 6), addr, 1'b0, '0, toggle);
      default: begin
        size = $urandom_range(0, 6);
        cSend(6, src, size, addr, '0);
        dExpect("rndRelease", 1, 6, size, src, 0, 1'b0, toggle);
      end
    endcase
  endtask

  initial begin
    reset   = 1'b1;
    a_valid = 1'b0;
    c_valid = 1'b0;
    d_ready = 1'b0;
    e_valid = 1'b0;
    aBits   = '0;
    cBits   = '0;
    eBits   = '0;

    repeat (2) @(negedge clock);
    #1;
    checkOutput("rstAReady", 256'(a_ready), 256'(0));
    checkOutput("rstCReady", 256'(c_ready), 256'(0));
    checkOutput("rstDValid", 256'(d_valid), 256'(0));
    checkOutput("rstEReady", 256'(e_ready), 256'(0));
    checkOutput("rstErr", 256'(err), 256'(0));
    checkOutput("rstDBits", 256'(dBits), 256'(0));
    c_valid = 1'b1;
    #1;
    checkOutput("rstCReadyValid", 256'(c_ready), 256'(0));
    c_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("idleAReady", 256'(a_ready), 256'(1));
    checkOutput("idleCReady", 256'(c_ready), 256'(1));

    for (int i = 0; i < MEM / 4; i++)
      releaseBurst($urandom_range(0, 15), 6, 32'(i * 64), 1'b0, '0, 1'b0);

    releaseBurst(2, 6, 32'h40, 1'b1, 128'hA0, 1'b0);
    aSend(4, 0, 9, 4, 32'h50);
    dExpect("getA1", 1, 1, 4, 9, 5, 1'b1, 1'b0);

    aSend(6, 1, 3, 6, 32'h40);
    dExpect("grantData", 4, 5, 6, 3, 4, 1'b1, 1'b0);
    eSend(SINK_ID);

    aSend(6, 1, 3, 6, 32'h40);
    dExpect("grantStall", 4, 5, 6, 3, 4, 1'b1, 1'b1);
    eSend(SINK_ID);

    @(negedge clock);
    cBits = '0; cBits.opcode = 3'd6; cBits.source = 4'd1; cBits.size = 4'd4; cBits.address = 32'h80;
    aBits = '0; aBits.opcode = 3'd4; aBits.source = 4'd5; aBits.size = 4'd4; aBits.address = 32'h80;
    c_valid = 1'b1;
    a_valid = 1'b1;
    #1;
    checkOutput("prioAReady", 256'(a_ready), 256'(0));
    checkOutput("prioCReady", 256'(c_ready), 256'(1));
    @(posedge clock); #1;
    c_valid = 1'b0;
    #1;
    checkOutput("aReadyCAck", 256'(a_ready), 256'(0));
    dExpect("prioAck", 1, 6, 4, 1, 0, 1'b0, 1'b0);
    checkOutput("prioAThen", 256'(a_ready), 256'(1));
    @(posedge clock); #1;
    a_valid = 1'b0;
    dExpect("prioGet", 1, 1, 4, 5, 8, 1'b1, 1'b0);

    cSend(4, 0, 4, 32'h0, '0);
    errExp = 1'b1;
    @(negedge clock); #1;
    checkOutput("probeNoD", 256'(d_valid), 256'(0));
    checkOutput("probeErr", 256'(err), 256'(errExp));
    aSend(4, 0, 7, 5, 32'h30);
    dExpect("getAfterErr", 2, 1, 5, 7, 2, 1'b1, 1'b0);
    @(negedge clock);
    reset  = 1'b1;
    errExp = 1'b0;
    #1;
    checkOutput("errCleared", 256'(err), 256'(errExp));
    @(negedge clock);
    reset = 1'b0;

    aSend(4, 0, 1, 7, 32'h70);
    errExp = 1'b1;
    dExpect("getSize7", 4, 1, 7, 1, 4, 1'b1, 1'b0);
    checkOutput("size7Err", 256'(err), 256'(errExp));

    aSend(6, 1, 3, 6, 32'h40);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      d_ready = 1'b1;
      #1;
      checkOutput("preRstValid", 256'(d_valid), 256'(1));
      checkOutput("preRstBeat", 256'(dBits), 256'(expD(5, 6, 3, refMem[4 + k])));
      @(posedge clock);
    end
    @(negedge clock);
    d_ready = 1'b0;
    #1;
    checkOutput("beat2Held", 256'(dBits), 256'(expD(5, 6, 3, refMem[6])));
    reset  = 1'b1;
    errExp = 1'b0;
    #1;
    checkOutput("midRstDValid", 256'(d_valid), 256'(0));
    checkOutput("midRstDBits", 256'(dBits), 256'(0));
    checkOutput("midRstErr", 256'(err), 256'(errExp));
    repeat (2) @(negedge clock);
    reset = 1'b0;
    aSend(6, 1, 3, 6, 32'h40);
    dExpect("grantAfterRst", 4, 5, 6, 3, 4, 1'b1, 1'b0);
    eSend(SINK_ID);

    repeat (30) applyStimulus();
    @(negedge clock); #1;
    checkOutput("finalErr", 256'(err), 256'(errExp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
